// File: rtl/pisr2_pkg.sv
// Shared types and helpers for the pisr2 parallel-in/serial-out transmitter.
package pisr2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Number of serial beats in one frame: data bits plus an optional parity bit.
  function automatic int frame_len(input int width, input int parity);
    return width + ((parity != PAR_NONE) ? 1 : 0);
  endfunction

endpackage

// File: rtl/pisr2_shreg.sv
// WIDTH+1-bit loadable shift register; the parity bit sits next to the last data bit
// so it falls out of the serial end right after the data.
module pisr2_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic             par,
  output logic             bit_out
);

  logic [WIDTH:0] sr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr <= '0;
    end else if (load) begin
      sr <= MSB_FIRST ? {din, par} : {par, din};
    end else if (shift) begin
      sr <= MSB_FIRST ? {sr[WIDTH-1:0], 1'b0} : {1'b0, sr[WIDTH:1]};
    end
  end

  assign bit_out = MSB_FIRST ? sr[WIDTH] : sr[0];

endmodule

// File: rtl/pisr2.sv
// Parallel-in/serial-out transmitter: accepts a word, emits it one bit per accepted
// beat with optional parity, then idles for GAP cycles before taking the next word.
module pisr2
  import pisr2_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] pin,
  input  logic             pin_valid,
  output logic             pin_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int N  = frame_len(WIDTH, PARITY);
  localparam int CW = $clog2(WIDTH + 2);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [3:0]      gcnt;
  logic            rdy_q;
  logic            cap, beat, par_bit, sh_out;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high at
  // the rising edge; valid holds its data until then, and ready never depends on valid.
  assign cap  = (state == ST_IDLE) & pin_valid & rdy_q;
  assign beat = (state == ST_SHIFT) & sout_ready;

  always_comb begin
    par_bit = 1'b0;
    if (PARITY == PAR_EVEN) par_bit = ^pin;
    else if (PARITY == PAR_ODD) par_bit = ~^pin;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cap) state_nx = ST_SHIFT;
      ST_SHIFT: if (beat && cnt == CW'(1)) state_nx = (GAP != 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gcnt <= 4'd1) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      rdy_q <= 1'b0;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= (state_nx == ST_IDLE);
      if (cap) cnt <= CW'(N);
      else if (beat) cnt <= cnt - 1'b1;
      if (beat && cnt == CW'(1)) gcnt <= 4'(GAP);
      else if (state == ST_GAP) gcnt <= gcnt - 4'd1;
    end
  end

  pisr2_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST != 0)
  ) u_shreg (
    .clk    (clk),
    .clr    (clr),
    .load   (cap),
    .shift  (beat),
    .din    (pin),
    .par    (par_bit),
    .bit_out(sh_out)
  );

  // Outputs decode registered state only, so a reset drops them immediately.
  assign pin_ready  = rdy_q;
  assign sout_valid = (state == ST_SHIFT);
  assign sout       = sout_valid & sh_out;
  assign sout_last  = sout_valid & (cnt == CW'(1));
  assign busy       = (state != ST_IDLE);

endmodule

// File: doc/pisr2.md
# pisr2

Parallel-in/serial-out shift register, the transmit-side counterpart of the serial-in parallel-shift register `psr2`. It accepts a WIDTH-bit word on a valid/ready handshake and serialises it one bit per accepted beat onto `sout`. It supports optional parity and a configurable inter-word idle gap. It sits between a word-oriented producer and a serial link that `psr2` (or equivalent) receives.

## Interface
- `WIDTH`, 8: data word width; legal range 1..32.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.
- `PARITY`, 0: 0 = none; 1 = even parity bit appended; 2 = odd parity bit appended.
- `GAP`, 1: idle cycles forced between words, range 0..15.
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous active-high reset.
- `pin`  in  WIDTH  parallel word to transmit.
- `pin_valid`  in  1  producer has a word on `pin`.
- `pin_ready`  out  1  block accepts a word this cycle.
- `sout`  out  1  serial data bit.
- `sout_valid`  out  1  `sout` holds a valid bit.
- `sout_ready`  in  1  consumer takes the bit this cycle.
- `sout_last`  out  1  current bit is the final bit of the frame (parity bit if enabled).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: `pin_ready`=1. On `pin_valid & pin_ready`, capture `pin` into the shift register, compute parity from `pin`, load the bit counter with N = WIDTH + (PARITY!=0), and go to SHIFT.
  - SHIFT: `sout_valid`=1. Present the current bit. On `sout_ready`, shift (left if MSB_FIRST, right otherwise), decrement the counter, and advance.
    - With parity enabled, the parity bit follows the data bits.
    - On the handshake with counter==1: go to GAP if GAP>0, else to IDLE.
  - GAP: `sout_valid`=0 and `sout`=0. A gap counter loaded with GAP decrements each cycle; go to IDLE when it expires (exactly GAP cycles).
- Stall: while `sout_ready`=0 in SHIFT, `sout`, `sout_last` and the counter hold; there is no bit loss and no duplication.
- `pin` is sampled only on the capture handshake; later changes to `pin` have no effect on the frame in flight.
- `pin_valid` in non-IDLE states is ignored. `pin_ready`=0 there, so no word is dropped silently; the producer holds the word.
- `sout_last` = (counter==1) & `sout_valid`.
- Parity:
  - Even: the parity bit is the XOR of the WIDTH data bits.
  - Odd: its inverse.
- WIDTH=1, PARITY=0: the frame is one beat, and `sout_last` is high on that beat.
- Reset mid-frame: the frame is abandoned, all state is cleared, and no partial frame resumes after `clr` falls.

## Timing
- Reset values while `clr`=1: state IDLE, `pin_ready`=0, `sout`=0, `sout_valid`=0, `sout_last`=0, `busy`=0, shift register and counters 0.
- `pin_ready` is registered. It rises on the first `clk` edge after `clr` deasserts, and on the edge that enters IDLE.
- Capture-to-first-bit latency is 1 cycle: capture at edge k, and `sout_valid`=1 with the first bit after edge k.
- Frame duration with no stalls is N cycles of SHIFT + GAP cycles + 1 IDLE cycle. Minimum word period is N+GAP+1 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from `sout_ready` or `pin_valid` to any output.

## Structure
- Package `pisr2_pkg`:
  - state enum (IDLE, SHIFT, GAP);
  - parity-mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - function `frame_len(width, parity)`.
- Sub-module `pisr2_shreg`:
  - WIDTH+1-bit loadable shift register with direction select, load, shift-enable, and async clear;
  - the parity bit is loaded into the extra position adjacent to the last data bit.
- FSM and counters live in the top level. Counter widths: bit counter $clog2(WIDTH+2), gap counter 4 bits.

## Test plan
- Reset: `clr` pulsed mid-frame after 3 bits of 0xA5 have shifted out.
  - Required: `sout_valid`/`sout` drop to 0 asynchronously, `pin_ready` returns 1 cycle after release, and the next word transmits in full.
- Basic MSB-first: WIDTH=8, PARITY=0, GAP=1, `pin`=0xA5, `sout_ready`=1.
  - Required: `sout` sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, `sout_last` on beat 8, 1 gap cycle, then `pin_ready`=1.
- LSB-first with even parity: MSB_FIRST=0, PARITY=1, `pin`=0x07.
  - Required: `sout` = 1,1,1,0,0,0,0,0 then parity bit 1, with `sout_last` on beat 9.
- Odd parity with stall: `pin`=0x00, PARITY=2, `sout_ready` low for 4 cycles after beat 2.
  - Required: `sout` holds beat-2 value during the stall, the frame totals 9 accepted beats, and the parity bit is 1.
- Back-to-back, GAP=0: `pin_valid` held high with 0x01 then 0xFF.
  - Required: frames separated by exactly 1 non-valid cycle (IDLE capture), and `pin_ready` pulses for exactly 1 cycle per word.
- WIDTH=1, PARITY=0, `pin`=1.
  - Required: a single beat with `sout`=1, `sout_last`=1, then the GAP cycles, then `pin_ready`.
